// File: rtl/aes128_defs.sv
// Shared definitions for the AES-128 inverse round-key streamer.
// FSM encoding, round count, RCON and GF(2^8) helpers.
package aes128_defs;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_EMIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // RCON[r-1] for round r, placed later in byte 0 of the word.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-schedule step, forward (dir=0) or inverse (dir=1).
// Both directions share the same four S-boxes via the source mux.
module aes128_key_step
    import aes128_defs::*;
(
    input  logic         dir,
    input  logic [3:0]   round,
    input  logic [127:0] key,
    output logic [127:0] key_nxt
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_p1, w_p2, w_p3;
    logic [31:0] w_src, w_rot, w_sub, w_t;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;

    assign {w_w0, w_w1, w_w2, w_w3} = key;

    assign w_p3 = w_w3 ^ w_w2;
    assign w_p2 = w_w2 ^ w_w1;
    assign w_p1 = w_w1 ^ w_w0;

    assign w_src = dir ? w_p3 : w_w3;
    assign w_rot = {w_src[23:0], w_src[31:24]};

    for (genvar j = 0; j < 4; j++) begin : g_sb
        sbox u_sbox (
            .i_byte (w_rot[8*j +: 8]),
            .o_byte (w_sub[8*j +: 8])
        );
    end

    assign w_t = w_sub ^ {rcon(round), 24'h0};

    assign w_f0 = w_w0 ^ w_t;
    assign w_f1 = w_w1 ^ w_f0;
    assign w_f2 = w_w2 ^ w_f1;
    assign w_f3 = w_w3 ^ w_f2;

    assign key_nxt = dir ? {w_w0 ^ w_t, w_p1, w_p2, w_p3}
                         : {w_f0, w_f1, w_f2, w_f3};

endmodule

// File: rtl/sbox.sv
// AES forward S-box: GF(2^8) inverse as x^254, then the affine map.
// x^254 is the product of x^2, x^4, ..., x^128 (0 maps to 0).
module sbox
    import aes128_defs::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    logic [7:0] w_x2, w_x4, w_x8, w_x16, w_x32, w_x64, w_x128;
    logic [7:0] w_inv;

    assign w_x2   = gmul(i_byte, i_byte);
    assign w_x4   = gmul(w_x2, w_x2);
    assign w_x8   = gmul(w_x4, w_x4);
    assign w_x16  = gmul(w_x8, w_x8);
    assign w_x32  = gmul(w_x16, w_x16);
    assign w_x64  = gmul(w_x32, w_x32);
    assign w_x128 = gmul(w_x64, w_x64);

    assign w_inv = gmul(gmul(gmul(w_x2, w_x4), gmul(w_x8, w_x16)),
                        gmul(gmul(w_x32, w_x64), w_x128));

    assign o_byte = w_inv
                  ^ {w_inv[6:0], w_inv[7]}
                  ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]}
                  ^ {w_inv[3:0], w_inv[7:4]}
                  ^ 8'h63;

endmodule

// File: rtl/aes128_inv_key_stream.sv
// AES-128 round-key streamer: expands forward to key 10, then
// emits keys 10..0 over valid/ready using the inverse schedule.
module aes128_inv_key_stream
    import aes128_defs::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic         replay,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx
);

    state_t       r_state, w_state;
    logic [127:0] r_k, w_k;
    logic [127:0] r_key10, w_key10;
    logic [3:0]   r_cnt, w_cnt;
    logic [3:0]   r_idx, w_idx;
    logic         w_dir;
    logic [3:0]   w_round;
    logic [127:0] w_step;

    assign w_dir   = (r_state == S_EMIT);
    assign w_round = w_dir ? r_idx : r_cnt;

    aes128_key_step u_step (
        .dir     (w_dir),
        .round   (w_round),
        .key     (w_k_src()),
        .key_nxt (w_step)
    );

    function automatic logic [127:0] w_k_src();
        return r_k;
    endfunction

    // Next-state and datapath updates; key_load overrides everything.
    always_comb begin
        w_state = r_state;
        w_k     = r_k;
        w_key10 = r_key10;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        if (key_load) begin
            w_k     = key_in;
            w_cnt   = 4'd1;
            w_state = S_EXPAND;
        end else begin
            unique case (r_state)
                S_IDLE: ;
                S_EXPAND: begin
                    w_k   = w_step;
                    w_cnt = r_cnt + 4'd1;
                    if (r_cnt == NR) begin
                        w_key10 = w_step;
                        w_idx   = NR;
                        w_state = S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (rk_ready) begin
                        if (r_idx != 4'd0) begin
                            w_k   = w_step;
                            w_idx = r_idx - 4'd1;
                        end else begin
                            w_state = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (replay) begin
                        w_k     = r_key10;
                        w_idx   = NR;
                        w_state = S_EMIT;
                    end
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_key10 <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state;
            r_k     <= w_k;
            r_key10 <= w_key10;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
        end
    end

    assign busy     = (r_state == S_EXPAND) || (r_state == S_EMIT);
    assign rk_valid = (r_state == S_EMIT);
    assign rk_out   = r_k;
    assign rk_idx   = r_idx;

endmodule

// File: tb/tb_aes128_inv_key_stream.sv
// Testbench for aes128_inv_key_stream.
// Reference: table S-box by brute-force inverse plus FIPS-197 expansion.
module tb_aes128_inv_key_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_load;
    logic         replay;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0]   sb_m [256];
    logic [127:0] rk_m [11];

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    aes128_inv_key_stream dut (
        .clk      (clk),
        .rst      (rst),
        .key_in   (key_in),
        .key_load (key_load),
        .replay   (replay),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] c, inv, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 0;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                     ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb_m[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            rk_m[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Pulse key_load and check the t+10 / t+11 valid edge.
    task automatic load_key(input logic [127:0] key, input logic with_replay);
        key_in   = key;
        key_load = 1'b1;
        replay   = with_replay;
        tick();
        key_load = 1'b0;
        replay   = 1'b0;
        chk("busy_after_load", busy, 1);
        for (int i = 0; i < 9; i++) tick();
        chk("valid_t10", rk_valid, 0);
        tick();
        chk("valid_t11", rk_valid, 1);
        chk("idx_t11", rk_idx, 10);
        chk("key10_t11", rk_out, rk_m[10]);
    endtask

    // Drain keys 10..0 with random backpressure against the model.
    task automatic stream(input string tag, input int pct);
        int  e;
        bit  done;
        e    = 10;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            rk_ready = ($urandom_range(99) < pct);
            chk({tag, "_valid"}, rk_valid, 1);
            chk({tag, "_idx"}, rk_idx, e);
            chk({tag, "_key"}, rk_out, rk_m[e]);
            tick();
            if (rk_ready) begin
                if (e == 0) done = 1;
                else e--;
            end
        end
        rk_ready = 1'b0;
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_valid"}, rk_valid, 0);
    endtask

    initial begin
        int e;
        int holds;
        logic [127:0] hold_k;
        logic [127:0] rk_first [11];

        rst      = 1'b1;
        key_in   = '0;
        key_load = 1'b0;
        replay   = 1'b0;
        rk_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_out", rk_out, 0);
        chk("rst_idx", rk_idx, 0);
        rst = 1'b0;

        build_sbox();

        // Load FIPS key, stream with a 5-cycle stall at index 7.
        model_expand(K_FIPS);
        rk_first = rk_m;
        rk_ready = 1'b1;
        load_key(K_FIPS, 1'b0);
        chk("fips_k10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        e     = 10;
        holds = 0;
        hold_k = '0;
        for (int c = 0; c < 40; c++) begin
            chk("bp_idx", rk_idx, e);
            chk("bp_key", rk_out, rk_m[e]);
            if (e == 7 && holds < 5) begin
                if (holds > 0) chk("bp_stable", rk_out, hold_k);
                hold_k   = rk_out;
                rk_ready = 1'b0;
                holds++;
                tick();
            end else begin
                rk_ready = 1'b1;
                if (e == 1) chk("fips_k1", rk_out,
                                128'ha0fafe1788542cb123a339392a6c7605);
                if (e == 0) chk("fips_k0", rk_out, K_FIPS);
                tick();
                if (e == 0) break;
                e--;
            end
        end
        chk("bp_holds", holds, 5);
        chk("done_busy", busy, 0);
        chk("done_valid", rk_valid, 0);

        // Replay from DONE repeats the first pass.
        replay = 1'b1;
        tick();
        replay = 1'b0;
        chk("replay_valid", rk_valid, 1);
        chk("replay_k10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rk_m = rk_first;
        stream("replay", 100);

        // Abort mid-emit by reloading at index 4.
        replay = 1'b1;
        tick();
        replay   = 1'b0;
        rk_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_idx", rk_idx, 4);
        model_expand(K_SEQ);
        load_key(K_SEQ, 1'b0);
        chk("seq_k10", rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        stream("abort", 60);

        // Random keys with random backpressure.
        for (int n = 0; n < 3; n++) begin
            logic [127:0] rk;
            rk = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rk);
            load_key(rk, 1'b0);
            stream("rand", 50);
        end

        // key_load and replay together from DONE: load wins.
        begin
            logic [127:0] rk;
            rk = {$urandom, $urandom, $urandom, $urandom};
            model_expand(rk);
            load_key(rk, 1'b1);
            stream("both", 100);
        end

        // Reset during EXPAND, then replay must be ignored.
        key_in   = K_FIPS;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", rk_valid, 0);
        chk("mid_rst_out", rk_out, 0);
        chk("mid_rst_idx", rk_idx, 0);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        chk("idle_replay_valid", rk_valid, 0);
        tick();
        chk("idle_replay_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
